mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one 32-bit memory port between two requesters: A = instruction fetch, B = data load/store.
- Sequences each transaction with a small FSM and round-robin fairness.
- Drives the 2:1 datapath select that steers address and write data onto the shared port.
- Sits between the CPU fetch/memory stages and the single memory interface.

Parameters:
- WIDTH, 32, data and address width of both requester ports and the memory port.
- TIMEOUT, 16, cycles to wait for mem_ready before aborting; used only with ARB_TIMEOUT_EN.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_a  input  1  requester A wants a transaction; held until done_a.
- addr_a  input  WIDTH  A address.
- wdata_a  input  WIDTH  A write data.
- we_a  input  1  A write enable.
- req_b, addr_b, wdata_b, we_b  input  1/WIDTH/WIDTH/1  same as A, for requester B.
- gnt_a  output  1  A owns the port.
- gnt_b  output  1  B owns the port.
- done_a  output  1  one-cycle pulse: A transaction complete.
- done_b  output  1  one-cycle pulse: B transaction complete.
- rdata  output  WIDTH  mem_rdata broadcast; valid in the done cycle.
- sel  output  1  mux control: 0 = A path, 1 = B path.
- mem_req  output  1  memory access strobe.
- mem_addr  output  WIDTH  muxed address.
- mem_wdata  output  WIDTH  muxed write data.
- mem_we  output  1  muxed write enable.
- mem_ready  input  1  memory completed the access this cycle.
- mem_rdata  input  WIDTH  memory read data.
- err  output  1  timeout abort pulse; tied 0 when the feature is off.

Behaviour:
- FSM states: IDLE, BUSY_A, BUSY_B. State, sel, last_grant and done/err are registers. The mem_addr/mem_wdata/mem_we mux is combinational from the registered sel.
- Reset (rst_n low, asynchronous): state=IDLE, sel=0, last_grant=B (A wins the first tie). gnt_a, gnt_b, done_a, done_b, mem_req and err all 0.
- IDLE:
  - Only req_a: go to BUSY_A, sel<=0.
  - Only req_b: go to BUSY_B, sel<=1.
  - Both: grant the requester not equal to last_grant.
  - Neither: stay in IDLE.
- BUSY_x:
  - mem_req=1 and gnt_x=1.
  - mem_addr/wdata/we come from requester x via sel.
  - Requester inputs must stay stable.
- mem_ready=1 in BUSY_x:
  - Next cycle: done_x=1 for exactly one cycle.
  - rdata is driven combinationally from mem_rdata in the completion cycle.
  - last_grant<=x and state<=IDLE.
- mem_ready while IDLE: ignored.
- Minimum transaction: request seen in IDLE at cycle 0; BUSY from cycle 1. With mem_ready at cycle 1, done pulses at cycle 2 and a new grant is possible at cycle 3.
- Back-to-back requests from both sides alternate A,B,A,B; neither starves.
- req_x dropping mid-transaction is ignored: the transaction runs to mem_ready and done_x still pulses.
- A new req arriving during BUSY waits and is arbitrated in the next IDLE cycle.
- rst_n asserted mid-transaction: immediate return to reset values. The pending transaction is dropped and no done is issued.

Optional Feature:
- ARB_TIMEOUT_EN defined:
  - A counter clears on BUSY entry and increments each BUSY cycle without mem_ready.
  - When it reaches TIMEOUT-1 without mem_ready: err pulses 1 cycle, done_x does not pulse, last_grant<=x, state<=IDLE.
  - Counter reset value is 0.
- Not defined: no counter, err tied 0, BUSY waits on mem_ready indefinitely.

Test Plan:
- Reset then req_a=1, addr_a=0x00000040, mem_ready on the first BUSY cycle → gnt_a=1, sel=0, mem_addr=0x00000040; done_a pulses one cycle; rdata=mem_rdata=0x12345678.
- req_a and req_b both held high for 4 transactions, mem_ready immediate → grant order A,B,A,B; sel toggles 0,1,0,1; exactly 2 done_a and 2 done_b pulses.
- req_b with we_b=1, wdata_b=0xDEADBEEF, mem_ready delayed 5 cycles → mem_we=1, mem_wdata=0xDEADBEEF held for 5 BUSY cycles; done_b pulses once.
- req_a dropped one cycle into BUSY_A, mem_ready at cycle 3 → transaction completes and done_a still pulses; req_b arriving meanwhile is granted only after IDLE.
- rst_n pulled low during BUSY_B → all outputs 0 within the same cycle; no done_b afterwards; state=IDLE.
- ARB_TIMEOUT_EN, TIMEOUT=16, mem_ready never asserted → err pulses after 16 BUSY cycles; no done; the other requester is granted next.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter for a single 32-bit memory port (A = fetch, B = load/store).
// Optional bus timeout abort is enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic [WIDTH-1:0] addr_a,
  input  logic [WIDTH-1:0] wdata_a,
  input  logic             we_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] addr_b,
  input  logic [WIDTH-1:0] wdata_b,
  input  logic             we_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             done_a,
  output logic             done_b,
  output logic [WIDTH-1:0] rdata,
  output logic             sel,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_we,
  input  logic             mem_ready,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, BUSY_A, BUSY_B} state_t;

  state_t state, state_nxt;
  logic   sel_nxt;
  logic   last_b, last_b_nxt;
  logic   done_a_nxt, done_b_nxt;
  logic   req_a_eff, req_b_eff;
  logic   abort;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT) + 1;
  logic [CW-1:0] tcnt;

  // Every BUSY entry passes through IDLE, so clearing there restarts the count per transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              tcnt <= '0;
    else if (state == IDLE)  tcnt <= '0;
    else if (!mem_ready)     tcnt <= tcnt + 1'b1;
  end

  assign abort = (state != IDLE) && !mem_ready && (tcnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else        err <= abort;
  end
`else
  // TIMEOUT only matters when the timer is built; the term folds to a constant 0.
  assign abort = 1'b0 & (TIMEOUT < 0);
  assign err   = 1'b0;
`endif

  // A requester keeps req high through its done cycle; that request belongs to the
  // finished transaction, so it must not win a fresh grant in that same cycle.
  assign req_a_eff = req_a & ~done_a;
  assign req_b_eff = req_b & ~done_b;

  always_comb begin
    state_nxt  = state;
    sel_nxt    = sel;
    last_b_nxt = last_b;
    done_a_nxt = 1'b0;
    done_b_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (req_a_eff && (!req_b_eff || last_b)) begin
          state_nxt = BUSY_A;
          sel_nxt   = 1'b0;
        end else if (req_b_eff) begin
          state_nxt = BUSY_B;
          sel_nxt   = 1'b1;
        end
      end
      BUSY_A: begin
        if (mem_ready || abort) begin
          done_a_nxt = mem_ready;
          last_b_nxt = 1'b0;
          state_nxt  = IDLE;
        end
      end
      BUSY_B: begin
        if (mem_ready || abort) begin
          done_b_nxt = mem_ready;
          last_b_nxt = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sel    <= 1'b0;
      last_b <= 1'b1;
      done_a <= 1'b0;
      done_b <= 1'b0;
    end else begin
      state  <= state_nxt;
      sel    <= sel_nxt;
      last_b <= last_b_nxt;
      done_a <= done_a_nxt;
      done_b <= done_b_nxt;
    end
  end

  assign gnt_a     = (state == BUSY_A);
  assign gnt_b     = (state == BUSY_B);
  assign mem_req   = (state != IDLE);
  assign mem_addr  = sel ? addr_b  : addr_a;
  assign mem_wdata = sel ? wdata_b : wdata_a;
  assign mem_we    = sel ? we_b    : we_a;
  assign rdata     = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, directed corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_mem_port_arbiter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_a, req_b, we_a, we_b, mem_ready;
  logic [W-1:0] addr_a, addr_b, wdata_a, wdata_b, mem_rdata;
  logic         gnt_a, gnt_b, done_a, done_b, sel, mem_req, mem_we, err;
  logic [W-1:0] rdata, mem_addr, mem_wdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.WIDTH(W), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .addr_a(addr_a), .wdata_a(wdata_a), .we_a(we_a),
    .req_b(req_b), .addr_b(addr_b), .wdata_b(wdata_b), .we_b(we_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .done_a(done_a), .done_b(done_b),
    .rdata(rdata), .sel(sel), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .err(err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct packed {
    logic ra, rb, rdy;
    logic ga, gb, da, db, sl, mr;
    logic [31:0] ad;
  } vec_t;

  vec_t tbl [12];

  // reference model state
  int   owner;     // 0 none, 1 A, 2 B
  bit   last_b_m, sel_m, da_m, db_m;
  int   wait_m;

  task automatic model_reset();
    owner = 0; last_b_m = 1'b1; sel_m = 1'b0; da_m = 1'b0; db_m = 1'b0; wait_m = 0;
  endtask

  task automatic model_step(input bit ra_in, input bit rb_in, input bit rdy);
    bit na, nb, ra, rb;
    na = (owner == 1) && rdy;
    nb = (owner == 2) && rdy;
    if (owner != 0) begin
      if (rdy) begin
        last_b_m = (owner == 2);
        owner = 0;
      end else wait_m++;
    end else begin
      ra = ra_in && !da_m;
      rb = rb_in && !db_m;
      if (ra && rb) owner = last_b_m ? 1 : 2;
      else if (ra)  owner = 1;
      else if (rb)  owner = 2;
      wait_m = 0;
      if (owner != 0) sel_m = (owner == 2);
    end
    da_m = na;
    db_m = nb;
  endtask

  initial begin
    int cnt, bcnt;
    bit seen;
    rst_n = 1'b0;
    {req_a, req_b, we_a, we_b, mem_ready} = '0;
    addr_a = 32'h0000_0040; addr_b = 32'h0000_0080;
    wdata_a = 32'h0; wdata_b = 32'h0; mem_rdata = 32'h1234_5678;

    tbl[0]  = '{1,1,0, 1,0,0,0,0,1, 32'h40};
    tbl[1]  = '{1,1,1, 0,0,1,0,0,0, 32'h40};
    tbl[2]  = '{1,1,0, 0,1,0,0,1,1, 32'h80};
    tbl[3]  = '{1,1,1, 0,0,0,1,1,0, 32'h80};
    tbl[4]  = '{1,1,0, 1,0,0,0,0,1, 32'h40};
    tbl[5]  = '{1,1,1, 0,0,1,0,0,0, 32'h40};
    tbl[6]  = '{1,1,0, 0,1,0,0,1,1, 32'h80};
    tbl[7]  = '{0,1,1, 0,0,0,1,1,0, 32'h80};
    tbl[8]  = '{0,0,0, 0,0,0,0,1,0, 32'h80};
    tbl[9]  = '{1,0,0, 1,0,0,0,0,1, 32'h40};
    tbl[10] = '{1,0,1, 0,0,1,0,0,0, 32'h40};
    tbl[11] = '{0,0,0, 0,0,0,0,0,0, 32'h40};

    repeat (2) @(negedge clk);
    chk("reset_outputs", {gnt_a, gnt_b, done_a, done_b, sel, mem_req, err}, 7'b0);
    rst_n = 1'b1;

    // vector table: alternation under contention, then a lone A read
    for (int i = 0; i < 12; i++) begin
      req_a = tbl[i].ra; req_b = tbl[i].rb; mem_ready = tbl[i].rdy;
      tick();
      chk($sformatf("vec%0d_ctl", i), {gnt_a, gnt_b, done_a, done_b, sel, mem_req},
          {tbl[i].ga, tbl[i].gb, tbl[i].da, tbl[i].db, tbl[i].sl, tbl[i].mr});
      chk($sformatf("vec%0d_addr", i), mem_addr, tbl[i].ad);
      chk($sformatf("vec%0d_rdata", i), rdata, 32'h1234_5678);
    end

    // B write with memory answering on the fifth BUSY cycle
    req_b = 1'b1; we_b = 1'b1; wdata_b = 32'hDEAD_BEEF; mem_ready = 1'b0;
    tick();
    for (int k = 1; k <= 5; k++) begin
      chk($sformatf("bwr_busy%0d", k), {gnt_b, sel, mem_we, done_b}, 4'b1110);
      chk($sformatf("bwr_wdata%0d", k), mem_wdata, 32'hDEAD_BEEF);
      if (k == 5) mem_ready = 1'b1;
      tick();
    end
    mem_ready = 1'b0;
    chk("bwr_done", {done_b, gnt_b}, 2'b10);
    req_b = 1'b0; we_b = 1'b0;
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (done_b) cnt++;
    end
    chk("bwr_single_done", cnt, 0);

    // A drops req mid-transaction; B arrives while busy and waits for IDLE
    req_a = 1'b1;
    tick();
    chk("drop_c1", {gnt_a, gnt_b}, 2'b10);
    req_a = 1'b0; req_b = 1'b1;
    tick();
    chk("drop_c2", {gnt_a, gnt_b}, 2'b10);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("drop_c3_done", {done_a, gnt_a, gnt_b}, 3'b100);
    tick();
    chk("drop_c4_bgrant", {gnt_b, sel}, 2'b11);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0; req_b = 1'b0;
    chk("drop_b_done", done_b, 1'b1);
    tick();

    // asynchronous reset during BUSY_B
    req_b = 1'b1;
    tick();
    chk("rst_busy_b", gnt_b, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", {gnt_a, gnt_b, done_a, done_b, sel, mem_req, err}, 7'b0);
    req_b = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (done_b || mem_req) cnt++;
    end
    chk("rst_no_done_idle", cnt, 0);

`ifdef ARB_TIMEOUT_EN
    // A never sees mem_ready; after the abort B must be served
    req_a = 1'b1; req_b = 1'b1;
    tick();
    bcnt = 0; seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (err) seen = 1'b1;
      else begin
        if (gnt_a) bcnt++;
        if (done_a) failures++;
        tick();
      end
    end
    chk("tmo_err_seen", seen, 1'b1);
    chk("tmo_busy_cycles", bcnt, 16);
    chk("tmo_no_done", done_a, 1'b0);
    req_a = 1'b0;
    tick();
    chk("tmo_err_pulse_b_gnt", {err, gnt_b}, 2'b01);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0; req_b = 1'b0;
    chk("tmo_b_done", done_b, 1'b1);
    tick();
`endif

    // randomized traffic against the reference model
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int n = 0; n < 1500; n++) begin
      if (da_m) req_a = 1'b0;
      if (db_m) req_b = 1'b0;
      if (!req_a && ($urandom % 4 == 0)) begin
        req_a = 1'b1; addr_a = $urandom; wdata_a = $urandom; we_a = 1'($urandom % 2);
      end
      if (!req_b && ($urandom % 4 == 0)) begin
        req_b = 1'b1; addr_b = $urandom; wdata_b = $urandom; we_b = 1'($urandom % 2);
      end
      mem_rdata = $urandom;
      if (owner == 0) mem_ready = 1'($urandom % 2);
      else mem_ready = ($urandom % 3 == 0) || (wait_m >= 8);
      @(posedge clk);
      model_step(req_a, req_b, mem_ready);
      @(negedge clk);
      chk($sformatf("rnd%0d_ctl", n), {gnt_a, gnt_b, done_a, done_b, sel, mem_req, err},
          {owner == 1, owner == 2, da_m, db_m, sel_m, owner != 0, 1'b0});
      chk($sformatf("rnd%0d_rdata", n), rdata, mem_rdata);
      if (owner != 0)
        chk($sformatf("rnd%0d_bus", n), {mem_addr ^ mem_wdata, 31'b0, mem_we},
            (owner == 1) ? {addr_a ^ wdata_a, 31'b0, we_a} : {addr_b ^ wdata_b, 31'b0, we_b});
      if (owner == 1) chk($sformatf("rnd%0d_addr", n), mem_addr, addr_a);
      if (owner == 2) chk($sformatf("rnd%0d_addr", n), mem_addr, addr_b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
